// File: rtl/tmds_wordalign.sv
// ============================================================================
// tmds_wordalign : TMDS 10-bit word aligner; hunts the bit offset on control
// token runs. Optional loss-of-lock: define TMDS_WORDALIGN_LOSS_DETECT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tmds_wordalign #(
  parameter int LGTIMEOUT = 12,
  parameter int NCTL      = 12
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [9:0] i_word,
  output logic [9:0] o_word,
  output logic       o_ctl_det,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int                   RUNW    = $clog2(NCTL + 1);
  localparam logic [LGTIMEOUT-1:0] TMO_MAX = {LGTIMEOUT{1'b1}};
  localparam logic [RUNW-1:0]      RUN_LOCK = RUNW'(NCTL);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           offset_q, offset_d;
  logic [RUNW-1:0]      run_q, run_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  logic [9:0]           last_q;
  logic [9:0]           word_q;
  logic                 ctl_q;

  logic [19:0]          cat_w;
  logic [19:0]          shifted_w;
  logic [9:0]           cand_w;
  logic                 is_ctl_w;
  logic [RUNW-1:0]      run_inc_w;
  logic [LGTIMEOUT-1:0] tmo_inc_w;
  logic                 lock_hit_w;
  logic                 tmo_hit_w;
  logic [3:0]           offset_nxt_w;

  // Candidate k is the 10-bit window starting k bits into the older word.
  assign cat_w     = {i_word, last_q};
  assign shifted_w = cat_w << offset_q;
  assign cand_w    = shifted_w[19:10];

  assign is_ctl_w = (cand_w == 10'h0AB) || (cand_w == 10'h354) ||
                    (cand_w == 10'h0AA) || (cand_w == 10'h355);

  assign run_inc_w    = run_q + RUNW'(1);
  assign tmo_inc_w    = tmo_q + LGTIMEOUT'(1);
  assign lock_hit_w   = is_ctl_w && (run_inc_w == RUN_LOCK);
  assign tmo_hit_w    = (tmo_inc_w == TMO_MAX);
  assign offset_nxt_w = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_HUNT: begin
        // A completed token run beats a simultaneous window expiry.
        if (lock_hit_w) begin
          state_d = ST_LOCKED;
          run_d   = '0;
          tmo_d   = '0;
        end else if (tmo_hit_w) begin
          offset_d = offset_nxt_w;
          run_d    = '0;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_inc_w;
          run_d = is_ctl_w ? run_inc_w : '0;
        end
      end
      ST_LOCKED: begin
        run_d = '0;
`ifdef TMDS_WORDALIGN_LOSS_DETECT_EN
        if (is_ctl_w) begin
          tmo_d = '0;
        end else if (tmo_hit_w) begin
          state_d = ST_HUNT;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_inc_w;
        end
`else
        tmo_d = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_HUNT;
      offset_q <= 4'd0;
      run_q    <= '0;
      tmo_q    <= '0;
      last_q   <= 10'd0;
      word_q   <= 10'd0;
      ctl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      last_q   <= i_word;
      word_q   <= cand_w;
      ctl_q    <= is_ctl_w;
    end
  end

  assign o_word    = word_q;
  assign o_ctl_det = ctl_q;
  assign o_locked  = (state_q == ST_LOCKED);
  assign o_offset  = offset_q;

endmodule

`default_nettype wire

// File: tb/tb_tmds_wordalign.sv
// ============================================================================
// tb_tmds_wordalign : directed scenarios plus a randomized run against a
// behavioural window/counter model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tmds_wordalign;

  localparam int LG   = 6;
  localparam int NC   = 4;
  localparam int TMAX = (1 << LG) - 1;

  logic       clk;
  logic       i_reset;
  logic [9:0] i_word;
  logic [9:0] o_word;
  logic       o_ctl_det;
  logic       o_locked;
  logic [3:0] o_offset;

  int n_checks;
  int n_fail;

  tmds_wordalign #(.LGTIMEOUT(LG), .NCTL(NC)) dut (
    .i_clk    (clk),
    .i_reset  (i_reset),
    .i_word   (i_word),
    .o_word   (o_word),
    .o_ctl_det(o_ctl_det),
    .o_locked (o_locked),
    .o_offset (o_offset)
  );

  always #5 clk = ~clk;

`ifdef TMDS_WORDALIGN_LOSS_DETECT_EN
  localparam bit LOSS = 1'b1;
`else
  localparam bit LOSS = 1'b0;
`endif

  task automatic tick(input logic [9:0] w, input logic r);
    i_word  = w;
    i_reset = r;
    @(posedge clk);
    #1;
  endtask

  // Received word carrying the current symbol tc at rotation r, with the
  // following symbol tn spilling into the top r bits.
  function automatic logic [9:0] rotpair(input logic [9:0] tn, input logic [9:0] tc, input int r);
    logic [19:0] c;
    c = {tn, tc} >> r;
    return c[9:0];
  endfunction

  function automatic bit is_tok(input int v);
    int toks[4];
    toks = '{'h0AB, 'h354, 'h0AA, 'h355};
    foreach (toks[i]) if (toks[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    tick(10'(($urandom)), 1'b1);
    tick(10'h354, 1'b1);
    n_checks++; if (o_word !== 10'h000) begin n_fail++; $display("FAIL reset_word: got %h want 000", o_word); end
    n_checks++; if (o_ctl_det !== 1'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0", o_ctl_det); end
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", o_locked); end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", o_offset); end
  endtask

  task automatic test_lock_rot0();
    tick(10'h0, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      tick(10'h354, 1'b0);
      if (n == 3) begin
        n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL lock0_early: got %b want 0", o_locked); end
      end
    end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock0_locked: got %b want 1", o_locked); end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL lock0_offset: got %0d want 0", o_offset); end
    n_checks++; if (o_word !== 10'h354) begin n_fail++; $display("FAIL lock0_word: got %h want 354", o_word); end
    n_checks++; if (o_ctl_det !== 1'b1) begin n_fail++; $display("FAIL lock0_ctl: got %b want 1", o_ctl_det); end
  endtask

  // Continues from a locked state at offset 0.
  task automatic test_loss();
    for (int n = 1; n <= 100; n++) begin
      tick(10'h000, 1'b0);
      if (n == 62) begin
        n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL loss_62: got %b want 1", o_locked); end
      end
      if (n == 63) begin
        n_checks++; if (o_locked !== !LOSS) begin n_fail++; $display("FAIL loss_63: got %b want %b", o_locked, !LOSS); end
      end
    end
    n_checks++; if (o_locked !== !LOSS) begin n_fail++; $display("FAIL loss_100: got %b want %b", o_locked, !LOSS); end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL loss_offset: got %0d want 0", o_offset); end
    n_checks++; if (o_ctl_det !== 1'b0) begin n_fail++; $display("FAIL loss_ctl: got %b want 0", o_ctl_det); end
  endtask

  task automatic test_hunt_rot3();
    tick(10'h0, 1'b1);
    for (int n = 1; n <= 193; n++) begin
      tick(rotpair(10'h354, 10'h354, 3), 1'b0);
      if (n == 62)  begin n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL hunt3_off62: got %0d want 0", o_offset); end end
      if (n == 63)  begin n_checks++; if (o_offset !== 4'd1) begin n_fail++; $display("FAIL hunt3_off63: got %0d want 1", o_offset); end end
      if (n == 126) begin n_checks++; if (o_offset !== 4'd2) begin n_fail++; $display("FAIL hunt3_off126: got %0d want 2", o_offset); end end
      if (n == 189) begin n_checks++; if (o_offset !== 4'd3) begin n_fail++; $display("FAIL hunt3_off189: got %0d want 3", o_offset); end end
      if (n == 192) begin n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL hunt3_early: got %b want 0", o_locked); end end
    end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL hunt3_locked: got %b want 1", o_locked); end
    n_checks++; if (o_offset !== 4'd3) begin n_fail++; $display("FAIL hunt3_offset: got %0d want 3", o_offset); end
    tick(rotpair(10'h0AB, 10'h354, 3), 1'b0);
    n_checks++; if (o_word !== 10'h354) begin n_fail++; $display("FAIL hunt3_word354: got %h want 354", o_word); end
    tick(rotpair(10'h0AB, 10'h0AB, 3), 1'b0);
    n_checks++; if (o_word !== 10'h0AB) begin n_fail++; $display("FAIL hunt3_word0ab: got %h want 0ab", o_word); end
    n_checks++; if (o_ctl_det !== 1'b1) begin n_fail++; $display("FAIL hunt3_ctl: got %b want 1", o_ctl_det); end
  endtask

  task automatic test_wrap();
    tick(10'h0, 1'b1);
    for (int n = 1; n <= 567; n++) tick(rotpair(10'h354, 10'h354, 9), 1'b0);
    n_checks++; if (o_offset !== 4'd9 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL wrap_at9: got off=%0d lock=%b want off=9 lock=0", o_offset, o_locked);
    end
    for (int n = 568; n <= 630; n++) begin
      tick(10'h000, 1'b0);
      if (n == 629) begin n_checks++; if (o_offset !== 4'd9) begin n_fail++; $display("FAIL wrap_629: got %0d want 9", o_offset); end end
    end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL wrap_630: got %0d want 0", o_offset); end
    for (int n = 0; n < 4; n++) tick(10'h354, 1'b0);
    n_checks++; if (o_locked !== 1'b1 || o_offset !== 4'd0) begin
      n_fail++; $display("FAIL wrap_relock: got lock=%b off=%0d want lock=1 off=0", o_locked, o_offset);
    end
  endtask

  task automatic test_lock_vs_timeout();
    logic [9:0] seq[8];
    seq = '{10'h354, 10'h354, 10'h354, 10'h2CC, 10'h354, 10'h354, 10'h354, 10'h354};
    tick(10'h0, 1'b1);
    for (int n = 1; n <= 55; n++) tick(10'h000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(seq[i], 1'b0);
      if (i == 3) begin
        n_checks++; if (o_ctl_det !== 1'b0) begin n_fail++; $display("FAIL ltm_2cc_ctl: got %b want 0", o_ctl_det); end
      end
      if (i == 6) begin
        n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL ltm_early: got %b want 0", o_locked); end
      end
    end
    n_checks++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL ltm_locked: got %b want 1", o_locked); end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL ltm_offset: got %0d want 0", o_offset); end
  endtask

  task automatic test_reset_locked();
    tick(10'h0, 1'b1);
    for (int n = 1; n <= 319; n++) tick(rotpair(10'h355, 10'h355, 5), 1'b0);
    n_checks++; if (o_locked !== 1'b1 || o_offset !== 4'd5) begin
      n_fail++; $display("FAIL rstlk_pre: got lock=%b off=%0d want lock=1 off=5", o_locked, o_offset);
    end
    tick(rotpair(10'h355, 10'h355, 5), 1'b1);
    n_checks++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL rstlk_locked: got %b want 0", o_locked); end
    n_checks++; if (o_offset !== 4'd0) begin n_fail++; $display("FAIL rstlk_offset: got %0d want 0", o_offset); end
    n_checks++; if (o_word !== 10'h000) begin n_fail++; $display("FAIL rstlk_word: got %h want 000", o_word); end
  endtask

  // Randomized bursts of tokens and noise at random rotations, against a model
  // that slides a window over the received bit stream.
  task automatic test_random();
    int m_last, m_off, m_run, m_tmo, m_word, win;
    bit m_lock, m_ctl, tok, r;
    int rot, seg_left;
    bit seg_tok;
    logic [9:0] seg_sym, t_cur, t_nxt, w;
    int toks[4];
    toks = '{'h0AB, 'h354, 'h0AA, 'h355};
    tick(10'h0, 1'b1);
    m_last = 0; m_off = 0; m_run = 0; m_tmo = 0; m_word = 0; m_lock = 0; m_ctl = 0;
    rot = $urandom_range(0, 9); seg_left = 0; seg_tok = 0; seg_sym = 10'h0;
    t_cur = 10'(($urandom)); t_nxt = 10'(($urandom));
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        seg_tok  = $urandom_range(0, 2) != 0;
        seg_left = $urandom_range(4, 90);
        seg_sym  = 10'(toks[$urandom_range(0, 3)]);
        if ($urandom_range(0, 3) == 0) rot = $urandom_range(0, 9);
      end
      seg_left--;
      w = rotpair(t_nxt, t_cur, rot);
      t_cur = t_nxt;
      t_nxt = seg_tok ? seg_sym : 10'(($urandom));
      r = ($urandom_range(0, 499) == 0);
      tick(w, r);
      if (r) begin
        m_last = 0; m_off = 0; m_run = 0; m_tmo = 0; m_word = 0; m_lock = 0; m_ctl = 0;
      end else begin
        win = (((int'(w) << 10) | m_last) >> (10 - m_off)) & 'h3FF;
        tok = is_tok(win);
        m_word = win; m_ctl = tok;
        if (!m_lock) begin
          m_run = tok ? m_run + 1 : 0;
          m_tmo = m_tmo + 1;
          if (m_run == NC) begin m_lock = 1; m_run = 0; m_tmo = 0; end
          else if (m_tmo == TMAX) begin m_off = (m_off + 1) % 10; m_run = 0; m_tmo = 0; end
        end else if (LOSS) begin
          m_tmo = tok ? 0 : m_tmo + 1;
          if (m_tmo == TMAX) begin m_lock = 0; m_tmo = 0; end
        end
        m_last = int'(w);
      end
      n_checks++;
      if (o_word !== 10'(m_word) || o_ctl_det !== m_ctl || o_locked !== m_lock || o_offset !== 4'(m_off)) begin
        n_fail++;
        $display("FAIL random_c%0d: got word=%h ctl=%b lock=%b off=%0d want word=%h ctl=%b lock=%b off=%0d",
                 c, o_word, o_ctl_det, o_locked, o_offset, 10'(m_word), m_ctl, m_lock, m_off);
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    i_reset  = 1'b1;
    i_word   = 10'h0;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lock_rot0();
    test_loss();
    test_hunt_rot3();
    test_wrap();
    test_lock_vs_timeout();
    test_reset_locked();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tmds_wordalign.md
TMDS_WORDALIGN -- requirements
Module: tmds_wordalign

Interface
REQ-001 SHALL have parameter LGTIMEOUT, default 12, meaning log2 of the hunt/loss window in words; legal only when 2^LGTIMEOUT > NCTL.
REQ-002 SHALL have parameter NCTL, default 12, meaning consecutive control tokens required to declare lock.
REQ-003 SHALL have port i_clk  input  1  system (pixel) clock; one clock domain, all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_word  input  10  raw deserialized TMDS word, arbitrary bit rotation, one per clock.
REQ-006 SHALL have port o_word  output  10  bit-aligned TMDS word, bit order as consumed by the TMDS decoder.
REQ-007 SHALL have port o_ctl_det  output  1  o_word is one of the four control tokens.
REQ-008 SHALL have port o_locked  output  1  alignment achieved.
REQ-009 SHALL have port o_offset  output  4  currently selected bit offset, 0..9.

Function
REQ-010 SHALL register last_word <= i_word every clock and form cat = {i_word, last_word} (20 bits).
REQ-011 SHALL define candidate(k) = cat[19-k:10-k] for k = 0..9; k=0 is i_word unmodified.
REQ-012 SHALL register o_word <= candidate(o_offset) each clock: 1-cycle latency.
REQ-013 SHALL treat 10'h0AB, 10'h354, 10'h0AA, 10'h355 (i_word bit order) as control tokens; o_ctl_det registered alongside o_word from the same candidate.
REQ-014 SHALL implement two states, HUNT and LOCKED; o_locked = (state == LOCKED).
REQ-015 In HUNT, SHALL increment run counter when candidate(o_offset) is a control token, else clear it to 0.
REQ-016 In HUNT, SHALL increment timeout counter each clock; counter width LGTIMEOUT.
REQ-017 In HUNT, when run counter reaches NCTL (the NCTL-th consecutive token), SHALL enter LOCKED on that edge, offset unchanged.
REQ-018 In HUNT, when timeout counter equals 2^LGTIMEOUT-1 without lock, SHALL advance o_offset by 1, 9 wrapping to 0, and clear both counters.
REQ-019 Lock and timeout on the same edge: lock SHALL win; offset not advanced.
REQ-020 In LOCKED, o_offset SHALL be frozen; run and timeout counters held at 0 except per REQ-026.
REQ-021 o_offset SHALL never take values 10..15.

Reset
REQ-022 On i_reset: state=HUNT, o_offset=0, run and timeout counters=0, last_word=0, o_word=0, o_ctl_det=0, o_locked=0.
REQ-023 Reset asserted mid-hunt or while locked SHALL take effect on the next edge and override all other transitions.
REQ-024 First clock after reset release SHALL begin hunting at offset 0 with timeout count starting from 0.

Configuration
REQ-025 Macro TMDS_WORDALIGN_LOSS_DETECT_EN SHALL select loss-of-lock detection.
REQ-026 Defined: in LOCKED, timeout counter increments each clock, clears on any control token at the candidate; at 2^LGTIMEOUT-1 SHALL return to HUNT, keep o_offset, clear counters.
REQ-027 Undefined: LOCKED SHALL persist until i_reset; no loss logic synthesized.

Verification (bench: LGTIMEOUT=6, NCTL=4)
REQ-028 Stream of 10'h354 at rotation 0 after reset -> o_locked=1 on the 4th token edge, o_offset=0, o_word=10'h354 with o_ctl_det=1.
REQ-029 Token stream rotated by 3 bits -> offset steps 0,1,2,3 at 63-clock intervals; lock at offset 3 within 4 tokens; o_word reads 10'h0AB/10'h354 as sent.
REQ-030 Rotation 9 not found at 0..8, then offset 9 times out -> o_offset wraps to 0, hunt continues; rotated data 0 then locks at 0.
REQ-031 3 tokens, one 10'h2CC, then 4 tokens, timed so the 4th token lands on the timeout edge -> lock wins, o_offset unchanged.
REQ-032 Locked, then 100 non-token words -> with LOSS_DETECT_EN: o_locked=0 after 63 clocks, o_offset held; without: o_locked stays 1.
REQ-033 i_reset pulsed while LOCKED at offset 5 -> next edge o_locked=0, o_offset=0, o_word=0.
